// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart receive path.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef struct packed {
    logic                  perr;
    logic [DATA_W_DEF-1:0] data;
  } rx_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  rx_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output rx_entry_t        rdata
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer with sticky overflow and watermark-hysteresis rts_n.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned HIGH_WM = 12,
  parameter int unsigned LOW_WM  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              parity_error,
  input  logic              flush,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  output logic              rts_n
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic             drop;
  logic             wr_en;
  logic             overflow_next;
  logic             rts_n_next;
  logic             rd_valid_next;
  logic             full_next;
  rx_entry_t        wr_entry;
  rx_entry_t        head;

  assign wr_entry = '{perr: parity_error, data: DATA_W_DEF'(rx_data)};

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word then.
  always_comb begin
    pop           = rd_valid && rd_ready;
    push          = rx_done && (!full || pop);
    drop          = rx_done && full && !pop;
    wr_en         = 1'b0;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = count;
    overflow_next = overflow;
    rts_n_next    = rts_n;

    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      wr_en = push;
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count - CNT_W'(1);
      end
      if (drop) begin
        overflow_next = 1'b1;
      end
    end

    // Hysteresis acts on the registered occupancy, so rts_n trails count by one edge.
    if (count >= CNT_W'(HIGH_WM)) begin
      rts_n_next = 1'b1;
    end else if (count <= CNT_W'(LOW_WM)) begin
      rts_n_next = 1'b0;
    end

    rd_valid_next = (count_next != '0);
    full_next     = (count_next == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rts_n    <= 1'b1;
      rd_valid <= 1'b0;
      full     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      overflow <= overflow_next;
      rts_n    <= rts_n_next;
      rd_valid <= rd_valid_next;
      full     <= full_next;
    end
  end

  assign rd_data = rd_valid ? DATA_W'(head.data) : '0;
  assign rd_perr = rd_valid ? head.perr : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model checked every cycle.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int HIGH_WM = 12;
  localparam int LOW_WM  = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;
  logic       flush;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       rts_n;

  uart_rx_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .flush        (flush),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .rts_n        (rts_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {perr, data}, sticky overflow, rts_n from last cycle's occupancy.
  logic [8:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_rts = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit do_pop;
    bit do_push;
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_rts = 1'b1;
    end else begin
      if (q.size() >= HIGH_WM) m_rts = 1'b1;
      else if (q.size() <= LOW_WM) m_rts = 1'b0;
      if (flush) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        do_pop  = (q.size() > 0) && rd_ready;
        do_push = rx_done && ((q.size() < DEPTH) || do_pop);
        if (rx_done && !do_push) m_ovf = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({parity_error, rx_data});
      end
    end
  endtask

  task automatic compare_all();
    check("rd_valid", int'(rd_valid), int'(q.size() > 0));
    check("count", int'(count), q.size());
    check("full", int'(full), int'(q.size() == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
    check("rts_n", int'(rts_n), int'(m_rts));
    if (q.size() > 0) begin
      check("rd_data", int'(rd_data), int'(q[0][7:0]));
      check("rd_perr", int'(rd_perr), int'(q[0][8]));
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at following negedge.
  task automatic tick(input logic rd, input logic done, input logic [7:0] d,
                      input logic pe, input logic fl);
    rd_ready     = rd;
    rx_done      = done;
    rx_data      = d;
    parity_error = pe;
    flush        = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic pe);
    tick(1'b0, 1'b1, d, pe, 1'b0);
  endtask

  task automatic pop();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx_data = '0; rx_done = 1'b0; parity_error = 1'b0; flush = 1'b0; rd_ready = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) idle();
    check("rst_rts_n", int'(rts_n), 1);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_perr", int'(rd_perr), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    idle();
    check("rel_rts_n", int'(rts_n), 0);

    // Single word
    push(8'hA5, 1'b0);
    check("single_valid", int'(rd_valid), 1);
    check("single_data", int'(rd_data), 'hA5);
    check("single_perr", int'(rd_perr), 0);
    pop();
    check("single_pop_valid", int'(rd_valid), 0);
    check("single_pop_count", int'(count), 0);

    // Hysteresis
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i), 1'b0);
    check("hy_count12", int'(count), 12);
    check("hy_rts_lag", int'(rts_n), 0);
    idle();
    check("hy_rts_high", int'(rts_n), 1);
    for (int i = 0; i < 7; i++) pop();
    check("hy_count5", int'(count), 5);
    idle();
    check("hy_rts_hold", int'(rts_n), 1);
    pop();
    check("hy_count4", int'(count), 4);
    idle();
    check("hy_rts_low", int'(rts_n), 0);
    for (int i = 0; i < 4; i++) pop();

    // Overflow
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("ov_full", int'(full), 1);
    push(8'hFF, 1'b0);
    check("ov_count", int'(count), 16);
    check("ov_flag", int'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      check("ov_drain", int'(rd_data), i);
      pop();
    end
    check("ov_empty", int'(rd_valid), 0);
    check("ov_sticky", int'(overflow), 1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ov_flush", int'(overflow), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b0);
    tick(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    check("fp_count", int'(count), 16);
    check("fp_overflow", int'(overflow), 0);
    check("fp_head", int'(rd_data), 'h41);
    for (int i = 0; i < 15; i++) pop();
    check("fp_last", int'(rd_data), 'h3C);
    pop();

    // Parity flag and wrap under continuous popping
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 8'(8'h80 + i), (i % 3) == 2, 1'b0);
    pop();
    pop();
    check("wrap_empty", int'(count), 0);

    // Flush wins over simultaneous push and pop
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1'b1);
    tick(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    check("fl_count", int'(count), 0);
    check("fl_valid", int'(rd_valid), 0);

    // Reset mid-stream discards entries and holds rts_n high
    for (int i = 0; i < 13; i++) push(8'(8'h20 + i), 1'b0);
    reset_n = 1'b0;
    idle();
    idle();
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_rts", int'(rts_n), 1);
    reset_n = 1'b1;
    idle();
    check("mid_rel_rts", int'(rts_n), 0);
    push(8'h5A, 1'b1);
    check("mid_data", int'(rd_data), 'h5A);
    check("mid_perr", int'(rd_perr), 1);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the uart receiver.
- Captures each received byte on the `rx_done` pulse, together with its parity-error flag, into a first-word-fall-through FIFO.
- Presents entries to the host over a valid/ready read port.
- Generates the `rts_n` flow-control output with watermark hysteresis, so the far-end transmitter pauses before the buffer overflows.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- DATA_W, 8, width of the received data word; matches the receiver's `rx_data`.
- HIGH_WM, 12, occupancy at or above which `rts_n` is deasserted (1); must satisfy LOW_WM < HIGH_WM <= DEPTH.
- LOW_WM, 4, occupancy at or below which `rts_n` is reasserted (0).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rx_data  input  DATA_W  received word from the uart receiver; valid only while `rx_done` is 1.
- rx_done  input  1  single-cycle pulse meaning one received word is complete.
- parity_error  input  1  parity error for the current word; sampled together with `rx_done`.
- flush  input  1  synchronous FIFO clear.
- rd_ready  input  1  host accepts the head entry this cycle.
- rd_valid  output  1  FIFO is non-empty; `rd_data` and `rd_perr` are valid.
- rd_data  output  DATA_W  head-entry data.
- rd_perr  output  1  head-entry parity-error flag.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a word arrives while the FIFO is full.
- rts_n  output  1  request-to-send, active-low; 0 means the sender may transmit.

Behaviour:
- Reset (`reset_n`=0 at a clk edge):
  - Write pointer, read pointer and count go to 0.
  - `overflow`=0, `rts_n`=1.
  - `rd_valid`=0, `rd_data`=0, `rd_perr`=0.
  - Reset applied mid-stream discards all entries, and `rts_n` is forced to 1 for the whole reset window.
- Push:
  - `rx_done`=1 and not full → write {`parity_error`, `rx_data`} at the write pointer.
  - The write pointer increments, wrapping from DEPTH-1 to 0.
- Pop:
  - `rd_valid`=1 and `rd_ready`=1 → the read pointer increments, with the same wrap.
  - `rd_ready` while empty has no effect.
- Occupancy:
  - count +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
- Output timing (first-word fall-through):
  - `rd_data`/`rd_perr` always show the entry at the read pointer.
  - `rd_valid` is registered: a word pushed into an empty FIFO gives `rd_valid`=1 on the cycle after `rx_done`. This latency of 1 is fixed; there is no same-cycle bypass.
- Full:
  - `rx_done` with count==DEPTH and no pop that cycle → word dropped, `overflow` set to 1 next cycle, count unchanged.
  - `rx_done` with count==DEPTH and a pop that same cycle → word accepted; no overflow.
- Overflow clear:
  - `overflow` stays 1 until `flush` or reset; it never self-clears.
- Flush:
  - Next edge: pointers=0, count=0, `rd_valid`=0, `overflow`=0.
  - Flush has priority over a simultaneous push or pop; both are ignored that cycle.
  - `rts_n` follows the normal rule with count=0.
- `rts_n` (registered, hysteresis):
  - Set to 1 on the cycle after count reaches ≥ HIGH_WM.
  - Cleared to 0 on the cycle after count falls to ≤ LOW_WM.
  - Holds its value when LOW_WM < count < HIGH_WM.
  - After reset release with count=0, `rts_n` becomes 0 on the first clk edge.
- Data width:
  - Received words narrower than DATA_W arrive zero-extended from the receiver and are stored unmodified.
- Simultaneous `rx_done` and `parity_error`:
  - Both are stored in the same entry; `parity_error` is ignored when `rx_done`=0.

Decomposition:
- uart_pkg holds:
  - DATA_W_DEF=8;
  - a typedef `rx_entry_t` packing {perr, data};
  - a function returning pointer width from DEPTH.
- One sub-module, uart_rx_fifo_mem:
  - DEPTH x `rx_entry_t` register array with a synchronous write port and an asynchronous read port.
  - No reset on the storage array.
- Pointer, count, overflow and `rts_n` logic stay in uart_rx_fifo.

Test Plan:
- Reset then idle:
  - hold `reset_n`=0 for 10 cycles and check `rts_n`=1, `rd_valid`=0, count=0;
  - release and check `rts_n`=0 on the next edge.
- Single word:
  - `rx_done` with `rx_data`=8'hA5, `parity_error`=0 → next cycle `rd_valid`=1, `rd_data`=8'hA5, `rd_perr`=0;
  - `rd_ready`=1 for one cycle → `rd_valid`=0, count=0.
- Hysteresis:
  - push 12 words with `rd_ready`=0 → `rts_n`=1 one cycle after the 12th push;
  - pop 7 words (count=5) → `rts_n` still 1;
  - pop an 8th word (count=4) → `rts_n`=0 next cycle.
- Overflow:
  - push 16 words 8'h00..8'h0F, then push 8'hFF with no pop → count stays 16, `overflow`=1;
  - drain → order is 00..0F with no FF;
  - `flush` → `overflow`=0.
- Full with simultaneous push+pop:
  - at count=16, `rx_done`(8'h3C) and `rd_ready` in the same cycle → count stays 16, `overflow`=0, and 8'h3C is the last word drained.
- Parity flag and wrap:
  - stream 40 words with `parity_error` on every 3rd word while popping continuously → read-side data and `rd_perr` match the push order across pointer wraps.
